// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
//   state_t : arbiter FSM states
//   owner_t : which requester owns the in-flight transaction
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (read-only) and the data
// requester (read/write). One transaction in flight, data has fixed priority,
// IF is forced through after STARVE_LIMIT consecutive data grants.
//
// Ports
//   clk, rst_n            : clock, synchronous active-low reset
//   if_req_* / if_resp_*  : IF read request / one-cycle read response
//   d_req_*  / d_resp_*   : data request / one-cycle response (rdata 0 on writes)
//   mem_req_*             : latched request towards memory, held until ready
//   mem_rvalid, mem_rdata : memory response (read data or write ack)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [AW-1:0]   if_req_addr,
    output logic            if_resp_valid,
    output logic [DW-1:0]   if_resp_rdata,

    input  logic            d_req_valid,
    output logic            d_req_ready,
    input  logic [AW-1:0]   d_req_addr,
    input  logic            d_req_we,
    input  logic [DW/8-1:0] d_req_wstrb,
    input  logic [DW-1:0]   d_req_wdata,
    output logic            d_resp_valid,
    output logic [DW-1:0]   d_resp_rdata,

    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_req_addr,
    output logic            mem_req_we,
    output logic [DW/8-1:0] mem_req_wstrb,
    output logic [DW-1:0]   mem_req_wdata,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    state_t        state, state_nxt;
    owner_t        owner;
    logic [CW-1:0] starve_cnt;
    logic          if_win, d_win;

    // Data wins ties unless IF has been passed over STARVE_LIMIT times.
    always_comb begin
        if_win = if_req_valid && (!d_req_valid || starve_cnt == LIMIT);
        d_win  = d_req_valid && !if_win;
    end

    // Readies are gated by rst_n so no handshake can complete in a reset cycle.
    assign if_req_ready  = rst_n && (state == IDLE) && if_win;
    assign d_req_ready   = rst_n && (state == IDLE) && d_win;

    assign mem_req_valid = (state == ISSUE);
    assign if_resp_valid = (state == RESP) && (owner == OWN_IF);
    assign d_resp_valid  = (state == RESP) && (owner == OWN_D);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (if_win || d_win) state_nxt = ISSUE;
            ISSUE: if (mem_req_ready)   state_nxt = WAIT;
            WAIT:  if (mem_rvalid)      state_nxt = RESP;
            RESP:                       state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            owner         <= OWN_IF;
            starve_cnt    <= '0;
            mem_req_addr  <= '0;
            mem_req_we    <= 1'b0;
            mem_req_wstrb <= '0;
            mem_req_wdata <= '0;
            if_resp_rdata <= '0;
            d_resp_rdata  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (if_req_ready) begin
                        owner         <= OWN_IF;
                        mem_req_addr  <= if_req_addr;
                        mem_req_we    <= 1'b0;
                        mem_req_wstrb <= '1;
                        mem_req_wdata <= '0;
                    end else if (d_req_ready) begin
                        owner         <= OWN_D;
                        mem_req_addr  <= d_req_addr;
                        mem_req_we    <= d_req_we;
                        mem_req_wstrb <= d_req_wstrb;
                        mem_req_wdata <= d_req_wdata;
                    end
                    // Only data grants made while IF is waiting count as starvation.
                    if (!if_req_valid || if_req_ready)
                        starve_cnt <= '0;
                    else if (d_req_ready && starve_cnt != LIMIT)
                        starve_cnt <= starve_cnt + 1'b1;
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        if (owner == OWN_IF)
                            if_resp_rdata <= mem_rdata;
                        else
                            d_resp_rdata  <= mem_req_we ? '0 : mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n)
            assert (!(mem_rvalid && state != WAIT))
            else $warning("mem_rvalid outside WAIT");
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int          AW = 32;
    localparam int          DW = 32;
    localparam logic [31:0] K  = 32'hDEADBFEF;  // memory returns addr ^ K

    logic            clk = 1'b0;
    logic            rst_n;
    logic            if_req_valid, if_req_ready, if_resp_valid;
    logic [AW-1:0]   if_req_addr;
    logic [DW-1:0]   if_resp_rdata;
    logic            d_req_valid, d_req_ready, d_req_we, d_resp_valid;
    logic [AW-1:0]   d_req_addr;
    logic [DW/8-1:0] d_req_wstrb;
    logic [DW-1:0]   d_req_wdata, d_resp_rdata;
    logic            mem_req_valid, mem_req_ready, mem_req_we, mem_rvalid;
    logic [AW-1:0]   mem_req_addr;
    logic [DW/8-1:0] mem_req_wstrb;
    logic [DW-1:0]   mem_req_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_resp_valid(if_resp_valid), .if_resp_rdata(if_resp_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_wstrb(d_req_wstrb), .d_req_wdata(d_req_wdata),
        .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_we(mem_req_we), .mem_req_wstrb(mem_req_wstrb), .mem_req_wdata(mem_req_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // Memory model: ready after stall_cnt cycles, rvalid the cycle after accept.
    logic        acc_q = 1'b0;
    logic [31:0] acc_addr = '0;
    int          stall_cnt = 0;
    bit          hold_resp = 0;
    logic        m_rvalid = 1'b0, inj_rvalid = 1'b0;
    assign mem_rvalid = m_rvalid | inj_rvalid;

    always @(posedge clk) begin
        if (!rst_n) acc_q <= 1'b0;
        else begin
            acc_q <= mem_req_valid && mem_req_ready;
            if (mem_req_valid && mem_req_ready) acc_addr <= mem_req_addr;
        end
    end

    always @(negedge clk) begin
        m_rvalid  = acc_q && !hold_resp;
        mem_rdata = acc_q ? (acc_addr ^ K) : 32'h0;
        if (mem_req_valid && stall_cnt > 0) begin
            mem_req_ready = 1'b0;
            stall_cnt--;
        end else
            mem_req_ready = mem_req_valid;
    end

    // Grant / response log: 1 = IF, 2 = data
    int gq[$], gc[$], rq[$];
    int cyc_n = 0;
    always @(posedge clk) begin
        if (rst_n) begin
            if (if_req_valid && if_req_ready) begin gq.push_back(1); gc.push_back(cyc_n); end
            if (d_req_valid && d_req_ready)   begin gq.push_back(2); gc.push_back(cyc_n); end
            if (if_resp_valid) rq.push_back(1);
            if (d_resp_valid)  rq.push_back(2);
        end
        cyc_n++;
    end

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_logs();
        gq.delete(); gc.delete(); rq.delete();
    endtask

    initial begin
        int mask;
        rst_n = 1'b0;
        if_req_valid = 0; if_req_addr = '0;
        d_req_valid = 0; d_req_addr = '0; d_req_we = 0; d_req_wstrb = '0; d_req_wdata = '0;
        mem_req_ready = 0; mem_rdata = '0;
        repeat (3) step();
        chk("rst_mem", {mem_req_valid, mem_req_we, mem_req_wstrb, mem_req_addr, mem_req_wdata}, '0);
        chk("rst_resp", {if_resp_valid, d_resp_valid, if_resp_rdata, d_resp_rdata}, '0);
        chk("rst_rdy", {if_req_ready, d_req_ready}, '0);
        rst_n = 1'b1;
        step();

        // T1: lone IF read
        clr_logs();
        if_req_valid = 1; if_req_addr = 32'h100;
        #1;
        chk("t1_if_rdy", {if_req_ready, d_req_ready}, 2'b10);
        step();
        if_req_valid = 0;
        chk("t1_mem_req", {mem_req_valid, mem_req_we, mem_req_wstrb, mem_req_addr, mem_req_wdata},
            {1'b1, 1'b0, 4'hF, 32'h100, 32'h0});
        step();
        chk("t1_no_resp_c2", if_resp_valid, 0);
        step();
        chk("t1_resp", {if_resp_valid, d_resp_valid, if_resp_rdata}, {1'b1, 1'b0, 32'hDEADBEEF});
        step();
        chk("t1_pulse_end", if_resp_valid, 0);
        chk("t1_rdata_hold", if_resp_rdata, 32'hDEADBEEF);
        chk("t1_resp_log", rq.size() == 1 ? rq[0] : 0, 1);

        // T2: both valid, data first then IF
        clr_logs();
        if_req_valid = 1; if_req_addr = 32'h200;
        d_req_valid = 1; d_req_we = 0; d_req_addr = 32'h8000;
        #1;
        chk("t2_d_first", {if_req_ready, d_req_ready}, 2'b01);
        step();
        d_req_valid = 0;
        for (int i = 0; i < 20 && !if_req_ready; i++) step();
        chk("t2_if_grant", if_req_ready, 1);
        step();
        if_req_valid = 0;
        for (int i = 0; i < 20 && rq.size() < 2; i++) step();
        chk("t2_grants", gq.size() == 2 ? gq[0] * 10 + gq[1] : 0, 21);
        chk("t2_gap", gc.size() == 2 ? gc[1] - gc[0] : 0, 4);
        chk("t2_resp_order", rq.size() == 2 ? rq[0] * 10 + rq[1] : 0, 21);
        chk("t2_d_rdata", d_resp_rdata, 32'h8000 ^ K);
        chk("t2_if_rdata", if_resp_rdata, 32'h200 ^ K);
        step();

        // T3: data write with 3-cycle ready stall
        clr_logs();
        stall_cnt = 3;
        d_req_valid = 1; d_req_we = 1; d_req_addr = 32'h8004;
        d_req_wdata = 32'h12345678; d_req_wstrb = 4'h3;
        #1;
        chk("t3_d_rdy", d_req_ready, 1);
        step();
        d_req_valid = 0; d_req_we = 0; d_req_wdata = '0; d_req_wstrb = '0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_stable%0d", i),
                {mem_req_valid, mem_req_we, mem_req_wstrb, mem_req_addr, mem_req_wdata},
                {1'b1, 1'b1, 4'h3, 32'h8004, 32'h12345678});
            step();
        end
        chk("t3_wait", {mem_req_valid, d_resp_valid}, 2'b00);
        step();
        chk("t3_ack", {d_resp_valid, d_resp_rdata}, {1'b1, 32'h0});
        step();

        // T4: both held valid -> D,D,D,D,IF repeating
        clr_logs();
        if_req_valid = 1; if_req_addr = 32'h300;
        d_req_valid = 1; d_req_we = 0; d_req_addr = 32'h9000;
        for (int i = 0; i < 100 && gq.size() < 10; i++) step();
        if_req_valid = 0; d_req_valid = 0;
        repeat (6) step();
        chk("t4_count", gq.size(), 10);
        mask = 0;
        for (int i = 0; i < gq.size() && i < 10; i++) if (gq[i] == 1) mask |= (1 << i);
        chk("t4_pattern", mask, 32'h210);

        // T5: reset in WAIT, late rvalid ignored, then normal request
        clr_logs();
        hold_resp = 1;
        if_req_valid = 1; if_req_addr = 32'h400;
        step();
        if_req_valid = 0;
        step();                                   // now in WAIT
        rst_n = 0; d_req_valid = 1; d_req_addr = 32'hA000;
        step();
        chk("t5_mem_zero", {mem_req_valid, mem_req_we, mem_req_wstrb, mem_req_addr, mem_req_wdata}, '0);
        chk("t5_resp_zero", {if_resp_valid, d_resp_valid, if_resp_rdata, d_resp_rdata}, '0);
        chk("t5_rdy_zero", {if_req_ready, d_req_ready}, '0);
        d_req_valid = 0;
        rst_n = 1; hold_resp = 0;
        inj_rvalid = 1;
        step();
        inj_rvalid = 0;
        repeat (3) step();
        chk("t5_no_resp", rq.size(), 0);
        if_req_valid = 1; if_req_addr = 32'h500;
        step();
        if_req_valid = 0;
        for (int i = 0; i < 20 && !if_resp_valid; i++) step();
        chk("t5_recover", {if_resp_valid, if_resp_rdata}, {1'b1, 32'h500 ^ K});
        step();

        // T6: stray rvalid in IDLE
        clr_logs();
        inj_rvalid = 1;
        step();
        inj_rvalid = 0;
        repeat (3) step();
        chk("t6_no_resp", rq.size(), 0);
        chk("t6_idle", mem_req_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
